// File: rtl/bank_biu_linefill.sv
// Linefill bus interface: turns HTU line requests into 2-beat AXI bursts and
// assembles the two 128-bit beats into one 256-bit line for the ISU.
//
// state | meaning
// IDLE  | waiting for the first beat of a pending line
// BEAT1 | low half captured, waiting for the second beat
// FULL  | line assembled, offered to ISU, R channel stalled
module bank_biu_linefill #(
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   input  logic                  htu_biu_req_valid_i,
   output logic                  htu_biu_req_ready_o,
   input  logic [2:0]            htu_biu_req_set_i,
   input  logic [2:0]            htu_biu_req_way_i,
   input  logic [ADDR_WIDTH-9:0] htu_biu_req_tag_i,

   output logic                  mem_arvalid_o,
   input  logic                  mem_arready_i,
   output logic [ADDR_WIDTH-1:0] mem_araddr_o,
   output logic [5:0]            mem_arid_o,
   output logic [7:0]            mem_arlen_o,
   output logic [2:0]            mem_arsize_o,
   output logic [1:0]            mem_arburst_o,

   input  logic                  mem_rvalid_i,
   output logic                  mem_rready_o,
   input  logic [127:0]          mem_rdata_i,
   input  logic [5:0]            mem_rid_i,
   input  logic                  mem_rlast_i,
   input  logic [1:0]            mem_rresp_i,

   output logic                  biu_isu_rvalid_o,
   input  logic                  biu_isu_rready_i,
   output logic [255:0]          biu_isu_rdata_o,
   output logic [5:0]            biu_isu_rid_o,
   output logic                  biu_isu_rerr_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT1 = 2'd1,
      ST_FULL  = 2'd2
   } rd_state_e;

   rd_state_e    state_q, state_d;
   logic [63:0]  pending_q, pending_d;
   logic [2:0]   cnt_q;
   logic [5:0]   req_id;
   logic         req_fire;
   logic         cap_lo, cap_hi, dlv_fire;
   logic [255:0] line_q;
   logic [5:0]   line_id_q;
   logic         line_err_q;

   assign req_id   = {htu_biu_req_set_i, htu_biu_req_way_i};
   // Accept may overlap the AR handshake of the previous request (zero-bubble).
   assign htu_biu_req_ready_o = (cnt_q < 3'(MAX_OUTSTANDING)) & ~pending_q[req_id]
                              & (~mem_arvalid_o | mem_arready_i);
   assign req_fire = htu_biu_req_valid_i & htu_biu_req_ready_o;

   assign mem_arlen_o   = 8'd1;
   assign mem_arsize_o  = 3'b100;
   assign mem_arburst_o = 2'b01;

   assign biu_isu_rdata_o = line_q;
   assign biu_isu_rid_o   = line_id_q;
   assign biu_isu_rerr_o  = line_err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_arvalid_o <= 1'b0;
         mem_araddr_o  <= '0;
         mem_arid_o    <= '0;
      end else if (req_fire) begin
         mem_arvalid_o <= 1'b1;
         mem_araddr_o  <= {htu_biu_req_tag_i, htu_biu_req_set_i, 5'b0};
         mem_arid_o    <= req_id;
      end else if (mem_arready_i) begin
         mem_arvalid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      mem_rready_o     = 1'b0;
      biu_isu_rvalid_o = 1'b0;
      cap_lo           = 1'b0;
      cap_hi           = 1'b0;
      dlv_fire         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            mem_rready_o = 1'b1;
            // Beats for lines nobody asked for (or abandoned by reset) are sunk.
            if (mem_rvalid_i && pending_q[mem_rid_i]) begin
               cap_lo  = 1'b1;
               state_d = mem_rlast_i ? ST_FULL : ST_BEAT1;
            end
         end
         ST_BEAT1: begin
            mem_rready_o = 1'b1;
            if (mem_rvalid_i) begin
               cap_hi  = 1'b1;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            biu_isu_rvalid_o = 1'b1;
            if (biu_isu_rready_i) begin
               dlv_fire = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q     <= '0;
         line_id_q  <= '0;
         line_err_q <= 1'b0;
      end else if (cap_lo) begin
         // Upper half is zeroed here; a normal second beat overwrites it.
         line_q     <= {128'd0, mem_rdata_i};
         line_id_q  <= mem_rid_i;
         line_err_q <= (mem_rresp_i != 2'b00) | mem_rlast_i;
      end else if (cap_hi) begin
         line_q[255:128] <= mem_rdata_i;
         line_err_q      <= line_err_q | (mem_rresp_i != 2'b00)
                          | (mem_rid_i != line_id_q) | ~mem_rlast_i;
      end
   end

   always_comb begin
      pending_d = pending_q;
      if (dlv_fire) pending_d[line_id_q] = 1'b0;
      if (req_fire) pending_d[req_id] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         pending_q <= pending_d;
         case ({req_fire, dlv_fire})
            2'b10:   cnt_q <= cnt_q + 3'd1;
            2'b01:   cnt_q <= cnt_q - 3'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_bank_biu_linefill.sv
// Directed bench for bank_biu_linefill: AR and ISU deliveries are checked
// against scoreboard queues filled as requests and beats are driven.
module tb_bank_biu_linefill;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_valid, req_ready;
   logic [2:0]    req_set, req_way;
   logic [23:0]   req_tag;
   logic          mem_arvalid, mem_arready;
   logic [31:0]   mem_araddr;
   logic [5:0]    mem_arid;
   logic [7:0]    mem_arlen;
   logic [2:0]    mem_arsize;
   logic [1:0]    mem_arburst;
   logic          mem_rvalid, mem_rready;
   logic [127:0]  mem_rdata;
   logic [5:0]    mem_rid;
   logic          mem_rlast;
   logic [1:0]    mem_rresp;
   logic          isu_rvalid, isu_rready;
   logic [255:0]  isu_rdata;
   logic [5:0]    isu_rid;
   logic          isu_rerr;

   int n_checks = 0;
   int n_errors = 0;

   logic [37:0]  ar_q[$];
   logic [262:0] exp_q[$];
   logic [37:0]  ar_e;
   logic [262:0] dl_e;

   always #5 clk_i = ~clk_i;

   bank_biu_linefill #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .htu_biu_req_valid_i (req_valid),
      .htu_biu_req_ready_o (req_ready),
      .htu_biu_req_set_i   (req_set),
      .htu_biu_req_way_i   (req_way),
      .htu_biu_req_tag_i   (req_tag),
      .mem_arvalid_o       (mem_arvalid),
      .mem_arready_i       (mem_arready),
      .mem_araddr_o        (mem_araddr),
      .mem_arid_o          (mem_arid),
      .mem_arlen_o         (mem_arlen),
      .mem_arsize_o        (mem_arsize),
      .mem_arburst_o       (mem_arburst),
      .mem_rvalid_i        (mem_rvalid),
      .mem_rready_o        (mem_rready),
      .mem_rdata_i         (mem_rdata),
      .mem_rid_i           (mem_rid),
      .mem_rlast_i         (mem_rlast),
      .mem_rresp_i         (mem_rresp),
      .biu_isu_rvalid_o    (isu_rvalid),
      .biu_isu_rready_i    (isu_rready),
      .biu_isu_rdata_o     (isu_rdata),
      .biu_isu_rid_o       (isu_rid),
      .biu_isu_rerr_o      (isu_rerr)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitors sample mid-cycle; inputs change 2 time units after each rising edge.
   always @(negedge clk_i) begin
      if (rst_ni && mem_arvalid && mem_arready) begin
         chk1("ar_expected", ar_q.size() != 0, 1'b1);
         if (ar_q.size() != 0) begin
            ar_e = ar_q.pop_front();
            chk32("araddr", mem_araddr, ar_e[37:6]);
            chk6("arid", mem_arid, ar_e[5:0]);
            chk32("ar_len_size_burst", {19'd0, mem_arlen, mem_arsize, mem_arburst},
                  {19'd0, 8'd1, 3'b100, 2'b01});
         end
      end
   end

   always @(negedge clk_i) begin
      if (rst_ni && isu_rvalid && isu_rready) begin
         chk1("dlv_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            dl_e = exp_q.pop_front();
            chk1("dlv_rerr", isu_rerr, dl_e[262]);
            chk6("dlv_rid", isu_rid, dl_e[261:256]);
            chk256("dlv_rdata", isu_rdata, dl_e[255:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic do_req(input logic [2:0] s, input logic [2:0] w, input logic [23:0] t);
      int k;
      k = 0;
      req_set = s; req_way = w; req_tag = t; req_valid = 1'b1;
      #1;
      while (!req_ready && k < 50) begin step(); #1; k++; end
      chk1("req_accept", req_ready, 1'b1);
      ar_q.push_back({t, s, 5'b0, s, w});
      step();
      req_valid = 1'b0;
   endtask

   task automatic do_beat(input logic [127:0] d, input logic [5:0] id,
                          input logic last, input logic [1:0] resp);
      int k;
      k = 0;
      mem_rvalid = 1'b1; mem_rdata = d; mem_rid = id; mem_rlast = last; mem_rresp = resp;
      #1;
      while (!mem_rready && k < 50) begin step(); #1; k++; end
      chk1("beat_accept", mem_rready, 1'b1);
      step();
      mem_rvalid = 1'b0;
   endtask

   task automatic fill(input logic [5:0] id, input logic [127:0] a, input logic [127:0] b,
                       input logic [5:0] rid2, input logic [1:0] resp2, input logic err);
      exp_q.push_back({err, id, b, a});
      do_beat(a, id, 1'b0, 2'b00);
      chk1("rvalid_after_beat1", isu_rvalid, 1'b0);
      do_beat(b, rid2, 1'b1, resp2);
      chk1("rvalid_latency", isu_rvalid, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] held;
      rst_ni = 1'b0;
      req_valid = 1'b0; req_set = '0; req_way = '0; req_tag = '0;
      mem_arready = 1'b1;
      mem_rvalid = 1'b0; mem_rdata = '0; mem_rid = '0; mem_rlast = 1'b0; mem_rresp = '0;
      isu_rready = 1'b1;
      step(); step();
      chk1("rst_arvalid", mem_arvalid, 1'b0);
      chk1("rst_rvalid", isu_rvalid, 1'b0);
      chk256("rst_rdata", isu_rdata, 256'd0);
      chk6("rst_rid", isu_rid, 6'd0);
      chk1("rst_rerr", isu_rerr, 1'b0);
      chk32("rst_araddr", mem_araddr, 32'd0);
      chk6("rst_arid", mem_arid, 6'd0);
      rst_ni = 1'b1;
      #1;
      chk1("post_rst_req_ready", req_ready, 1'b1);
      chk1("post_rst_rready", mem_rready, 1'b1);
      step();

      // Single fill, set 3 way 5.
      do_req(3'd3, 3'd5, 24'h123456);
      chk1("arvalid_after_accept", mem_arvalid, 1'b1);
      chk32("araddr_single", mem_araddr, 32'h12345660);
      fill(6'h1D, {32{4'hA}}, {32{4'hB}}, 6'h1D, 2'b00, 1'b0);
      step();

      // Four outstanding with AR backpressure, then the limit.
      mem_arready = 1'b0;
      do_req(3'd0, 3'd1, 24'h000100);
      req_set = 3'd1; req_way = 3'd2; req_tag = 24'h000200; req_valid = 1'b1;
      #1;
      chk1("ar_backpressure_ready", req_ready, 1'b0);
      step();
      chk1("ar_hold_valid", mem_arvalid, 1'b1);
      chk32("ar_hold_addr", mem_araddr, 32'h00010000);
      mem_arready = 1'b1;
      do_req(3'd1, 3'd2, 24'h000200);
      do_req(3'd2, 3'd3, 24'h000300);
      do_req(3'd4, 3'd4, 24'h000400);
      req_set = 3'd5; req_way = 3'd6; req_tag = 24'h000500; req_valid = 1'b1;
      #1;
      chk1("max_outstanding_ready", req_ready, 1'b0);
      step(); step();
      #1;
      chk1("max_outstanding_hold", req_ready, 1'b0);
      fill(6'h01, {4{32'h0101_0101}}, {4{32'h1111_1111}}, 6'h01, 2'b00, 1'b0);
      #1;
      chk1("ready_in_deliver_cycle", req_ready, 1'b0);
      step();
      #1;
      chk1("ready_after_deliver", req_ready, 1'b1);
      ar_q.push_back({24'h000500, 3'd5, 5'b0, 3'd5, 3'd6});
      step();
      req_valid = 1'b0;
      fill(6'h0A, {4{32'h0A0A_0A0A}}, {4{32'hA0A0_A0A0}}, 6'h0A, 2'b00, 1'b0);
      fill(6'h13, {4{32'h1313_1313}}, {4{32'h3131_3131}}, 6'h13, 2'b00, 1'b0);
      fill(6'h24, {4{32'h2424_2424}}, {4{32'h4242_4242}}, 6'h24, 2'b00, 1'b0);
      fill(6'h2E, {4{32'h2E2E_2E2E}}, {4{32'hE2E2_E2E2}}, 6'h2E, 2'b00, 1'b0);
      step();

      // ISU stall in FULL.
      do_req(3'd6, 3'd7, 24'hABCDEF);
      isu_rready = 1'b0;
      fill(6'h37, {4{32'h3737_0001}}, {4{32'h3737_0002}}, 6'h37, 2'b00, 1'b0);
      held = {{4{32'h3737_0002}}, {4{32'h3737_0001}}};
      for (int i = 0; i < 10; i++) begin
         step();
         chk1("stall_rready", mem_rready, 1'b0);
         chk1("stall_rvalid", isu_rvalid, 1'b1);
         chk256("stall_rdata", isu_rdata, held);
         chk6("stall_rid", isu_rid, 6'h37);
      end
      req_set = 3'd6; req_way = 3'd7; req_valid = 1'b1;
      #1;
      chk1("stall_still_pending", req_ready, 1'b0);
      req_valid = 1'b0;
      isu_rready = 1'b1;
      step(); step();

      // Error cases: bad resp on beat 2, early rlast, rid mismatch on beat 2.
      do_req(3'd7, 3'd0, 24'h000011);
      fill(6'h38, {4{32'h3800_0001}}, {4{32'h3800_0002}}, 6'h38, 2'b10, 1'b1);
      step();
      do_req(3'd7, 3'd1, 24'h000012);
      exp_q.push_back({1'b1, 6'h39, 128'd0, {4{32'h3900_0001}}});
      do_beat({4{32'h3900_0001}}, 6'h39, 1'b1, 2'b00);
      chk1("early_rlast_full", isu_rvalid, 1'b1);
      step();
      req_set = 3'd7; req_way = 3'd1; req_valid = 1'b1;
      #1;
      chk1("err_pending_cleared", req_ready, 1'b1);
      req_valid = 1'b0;
      do_req(3'd0, 3'd0, 24'h000013);
      fill(6'h00, {4{32'h0000_0C01}}, {4{32'h0000_0C02}}, 6'h05, 2'b00, 1'b1);
      step();

      // Duplicate id, stray beats, same-cycle accept and deliver.
      do_req(3'd2, 3'd2, 24'h000022);
      req_set = 3'd2; req_way = 3'd2; req_valid = 1'b1;
      #1;
      chk1("dup_id_ready", req_ready, 1'b0);
      req_valid = 1'b0;
      do_beat({4{32'hDEAD_BEEF}}, 6'h3F, 1'b0, 2'b00);
      chk1("stray_no_rvalid", isu_rvalid, 1'b0);
      chk1("stray_idle_rready", mem_rready, 1'b1);
      do_beat({4{32'hDEAD_BEEF}}, 6'h3E, 1'b1, 2'b00);
      chk1("stray2_no_rvalid", isu_rvalid, 1'b0);
      fill(6'h12, {4{32'h1200_0001}}, {4{32'h1200_0002}}, 6'h12, 2'b00, 1'b0);
      req_set = 3'd2; req_way = 3'd2; req_valid = 1'b1;
      #1;
      chk1("reaccept_delivering", req_ready, 1'b0);
      req_way = 3'd3; req_tag = 24'h000023;
      #1;
      chk1("accept_during_deliver", req_ready, 1'b1);
      ar_q.push_back({24'h000023, 3'd2, 5'b0, 3'd2, 3'd3});
      step();
      req_valid = 1'b0;
      step();

      // Reset in BEAT1 abandons everything in flight.
      do_req(3'd3, 3'd3, 24'h000033);
      step();
      do_beat({4{32'h1B00_0001}}, 6'h1B, 1'b0, 2'b00);
      rst_ni = 1'b0;
      #1;
      chk1("midrst_arvalid", mem_arvalid, 1'b0);
      chk1("midrst_rvalid", isu_rvalid, 1'b0);
      chk256("midrst_rdata", isu_rdata, 256'd0);
      chk6("midrst_rid", isu_rid, 6'd0);
      chk1("midrst_rerr", isu_rerr, 1'b0);
      chk32("midrst_araddr", mem_araddr, 32'd0);
      chk6("midrst_arid", mem_arid, 6'd0);
      step();
      rst_ni = 1'b1;
      req_set = 3'd2; req_way = 3'd3;
      #1;
      chk1("midrst_req_ready", req_ready, 1'b1);
      chk1("midrst_rready", mem_rready, 1'b1);
      step();
      do_beat({4{32'h1B00_0002}}, 6'h1B, 1'b0, 2'b00);
      do_beat({4{32'h1B00_0003}}, 6'h1B, 1'b1, 2'b00);
      chk1("post_rst_stray_dropped", isu_rvalid, 1'b0);

      step(); step();
      chk32("ar_queue_drained", ar_q.size(), 32'd0);
      chk32("exp_queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bank_biu_linefill.md
BANK_BIU_LINEFILL -- requirements
Module: bank_biu_linefill

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of the memory read channel.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum linefills in flight (accepted, not yet delivered to ISU); legal range 1..7.
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 htu_biu_req_valid_i  input  1  linefill request valid.
REQ-006 htu_biu_req_ready_o  output  1  linefill request accepted this cycle when high with valid.
REQ-007 htu_biu_req_set_i  input  3  set index; htu_biu_req_way_i input 3 way index; htu_biu_req_tag_i input ADDR_WIDTH-8 line tag.
REQ-008 mem_arvalid_o  output  1; mem_arready_i input 1; mem_araddr_o output ADDR_WIDTH; mem_arid_o output 6; mem_arlen_o output 8; mem_arsize_o output 3; mem_arburst_o output 2 -- AXI read address channel.
REQ-009 mem_rvalid_i  input  1; mem_rready_o output 1; mem_rdata_i input 128; mem_rid_i input 6; mem_rlast_i input 1; mem_rresp_i input 2 -- AXI read data channel.
REQ-010 biu_isu_rvalid_o  output  1; biu_isu_rready_i input 1; biu_isu_rdata_o output 256; biu_isu_rid_o output 6 ({set,way}); biu_isu_rerr_o output 1 -- full-line delivery to ISU.

Function
REQ-011 Line id SHALL be {set[2:0],way[2:0]}; mem_araddr_o SHALL be {tag,set,5'b0}; mem_arlen_o SHALL be 8'd1, mem_arsize_o 3'b100, mem_arburst_o 2'b01, constant.
REQ-012 A 64-bit pending bitmap SHALL mark ids accepted and not yet delivered; 3-bit counter cnt SHALL hold their number.
REQ-013 htu_biu_req_ready_o SHALL equal (cnt < MAX_OUTSTANDING) & ~pending[id] & (~mem_arvalid_o | mem_arready_i), combinational from inputs/state.
REQ-014 On request handshake: AR register loaded (arvalid=1 next cycle), pending[id] set, cnt+1.
REQ-015 mem_arvalid_o and AR payload SHALL stay stable until mem_arready_i; back-to-back accept SHALL be possible in the AR handshake cycle (zero-bubble).
REQ-016 Read FSM states IDLE, BEAT1, FULL; mem_rready_o=1 in IDLE and BEAT1, 0 in FULL.
REQ-017 IDLE: beat with ~pending[rid] SHALL be dropped, no state change; otherwise rdata stored to bits [127:0], rid captured, err=(rresp!=0); rlast=0 -> BEAT1; rlast=1 -> FULL with [255:128]=0 and err=1.
REQ-018 BEAT1: beat stored to [255:128]; err |= (rresp!=0) | (rid != captured id) | ~rlast; -> FULL.
REQ-019 FULL: biu_isu_rvalid_o=1 with rdata/rid/rerr stable; on biu_isu_rready_i -> IDLE, pending[id] cleared, cnt-1.
REQ-020 Latency: biu_isu_rvalid_o SHALL rise the cycle after the second beat handshake.
REQ-021 Same-cycle accept and delivery SHALL leave cnt unchanged and apply both bitmap updates; an id being delivered SHALL NOT be re-accepted that cycle.
REQ-022 cnt SHALL never exceed MAX_OUTSTANDING nor underflow.

Reset
REQ-023 While rst_ni=0: FSM IDLE, cnt=0, pending=0, mem_arvalid_o=0, biu_isu_rvalid_o=0, biu_isu_rdata_o=0, biu_isu_rid_o=0, biu_isu_rerr_o=0, mem_araddr_o=0, mem_arid_o=0.
REQ-024 Reset mid-operation SHALL abandon all in-flight linefills; beats arriving after reset SHALL be dropped per REQ-017.
REQ-025 mem_rready_o SHALL be 1 and htu_biu_req_ready_o SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-026 Single fill: set=3,way=5,tag=0x123456, arready=1; R beats 0xA..,0xB.. rid=0x1D -> araddr=0x12345660, arid=0x1D, rvalid_o one cycle after beat 2, rdata={0xB..,0xA..}, rerr=0.
REQ-027 Fill 4 distinct ids with arready=0 then 1 -> 5th request ready=0 until first delivery handshake; AR order preserved.
REQ-028 Hold biu_isu_rready_i=0 for 10 cycles in FULL -> mem_rready_o=0, outputs stable, cnt unchanged.
REQ-029 Beat 2 with rresp=2'b10, or rlast on beat 1 -> rerr=1, pending cleared on delivery.
REQ-030 Duplicate id while pending -> ready=0; stray R beat with unpending rid -> dropped, FSM stays IDLE.
REQ-031 Assert rst_ni=0 in BEAT1 -> all outputs reset values next edge; post-reset stray beat dropped.
